// File: rtl/polyvec_pointwise_acc_engine_if.sv
// Bus between the matrix-vector controller and the pointwise-accumulate engine.
// Optional feature macro: POLYVEC_ACC_INIT_EN adds the w_init accumulator seed.
interface polyvec_pointwise_acc_engine_if #(
    parameter int L = 5,
    parameter int N = 256,
    parameter int W = 32
);
    logic               start;
    logic [L*N*W-1:0]   u_in;
    logic [L*N*W-1:0]   v_in;
`ifdef POLYVEC_ACC_INIT_EN
    logic [N*W-1:0]     w_init;
`endif
    logic [N*W-1:0]     w_out;
    logic               busy;
    logic               done;

`ifdef POLYVEC_ACC_INIT_EN
    modport master (output start, u_in, v_in, w_init, input w_out, busy, done);
    modport slave  (input start, u_in, v_in, w_init, output w_out, busy, done);
`else
    modport master (output start, u_in, v_in, input w_out, busy, done);
    modport slave  (input start, u_in, v_in, output w_out, busy, done);
`endif
endinterface

// File: rtl/polyvec_pointwise_acc_engine.sv
// Dilithium vector pointwise multiply-accumulate: w = sum_i mont(u[i] .* v[i]).
// LANES coefficients per cycle through a two-stage pipeline (Montgomery multiply,
// then accumulate into the registered result). Optional macro POLYVEC_ACC_INIT_EN
// seeds the accumulator from w_init instead of zero on accept.
module polyvec_pointwise_acc_engine #(
    parameter int L     = 5,
    parameter int N     = 256,
    parameter int W     = 32,
    parameter int LANES = 16,
    parameter int Q     = 8380417,
    parameter int QINV  = 58728449
) (
    input  logic clock,
    input  logic reset,
    polyvec_pointwise_acc_engine_if.slave bus_if
);
    localparam int CH = N / LANES;
    localparam int PW = (L > 1) ? $clog2(L) : 1;
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;

    localparam logic [31:0]        QINV_U = 32'(QINV);
    localparam logic signed [63:0] Q_S64  = 64'(Q);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   p_q, p_d;
    logic [CW-1:0]   c_q, c_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            issue;
    logic            accept;

    logic            s1_valid_q;
    logic [CW-1:0]   s1_chunk_q;
    logic [W-1:0]    s1_prod_q [LANES];
    logic [W-1:0]    s1_prod_d [LANES];

    logic [W-1:0]    w_acc_q [N];

    function automatic logic signed [63:0] sext64(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

    // r = (a - t*Q) >>> 32 with t = low32(a) * QINV taken as signed; low 32 bits kept.
    function automatic logic [31:0] mont_reduce(input logic signed [63:0] a);
        logic [31:0]        t;
        logic signed [63:0] r;
        t = a[31:0] * QINV_U;
        r = (a - sext64(t) * Q_S64) >>> 32;
        return r[31:0];
    endfunction

    assign accept = (state_q == S_IDLE) && bus_if.start;

    // State, counters and status flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            p_q     <= '0;
            c_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: sequential state is updated with <= so every register samples pre-edge values.
            state_q <= state_d;
            p_q     <= p_d;
            c_q     <= c_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: walk (p, c) over every chunk of every polynomial, then drain.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        state_d = state_q;
        p_d     = p_q;
        c_d     = c_q;
        busy_d  = busy_q;
        done_d  = done_q;
        issue   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus_if.start) begin
                    state_d = S_RUN;
                    p_d     = '0;
                    c_d     = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                end
            end
            S_RUN: begin
                issue = 1'b1;
                if (c_q == CW'(CH - 1)) begin
                    c_d = '0;
                    if (p_q == PW'(L - 1)) begin
                        p_d     = '0;
                        state_d = S_DRAIN;
                    end else begin
                        p_d = p_q + PW'(1);
                    end
                end else begin
                    c_d = c_q + CW'(1);
                end
            end
            S_DRAIN: begin
                if (!s1_valid_q) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                if (!bus_if.start) begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Stage-1 datapath: Montgomery products of the current chunk of u[p] and v[p].
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            s1_prod_d[k] = mont_reduce(
                sext64(bus_if.u_in[N*W*int'(p_q) + W*(int'(c_q)*LANES + k) +: W]) *
                sext64(bus_if.v_in[N*W*int'(p_q) + W*(int'(c_q)*LANES + k) +: W]));
        end
    end

    // Stage-1 control: valid bit and chunk tag travel with the products.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_chunk_q <= '0;
        end else begin
            s1_valid_q <= issue;
            if (issue) s1_chunk_q <= c_q;
        end
    end

    // Stage-1 products: pure data qualified by s1_valid_q.
    always_ff @(posedge clock) begin
        // NOTE: the product registers carry no reset; nothing reads them while s1_valid_q is low.
        if (issue) s1_prod_q <= s1_prod_d;
    end

    // Stage 2: seed on accept, then wraparound-add each valid chunk into its slice.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the accumulator array is reset because it is the visible w_out value.
            w_acc_q <= '{default: '0};
        end else if (accept) begin
            for (int j = 0; j < N; j++) begin
`ifdef POLYVEC_ACC_INIT_EN
                w_acc_q[j] <= bus_if.w_init[W*j +: W];
`else
                w_acc_q[j] <= '0;
`endif
            end
        end else if (s1_valid_q) begin
            for (int k = 0; k < LANES; k++) begin
                w_acc_q[int'(s1_chunk_q)*LANES + k] <=
                    w_acc_q[int'(s1_chunk_q)*LANES + k] + s1_prod_q[k];
            end
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_wout
        assign bus_if.w_out[W*j +: W] = w_acc_q[j];
    end

    assign bus_if.busy = busy_q;
    assign bus_if.done = done_q;

endmodule

// File: tb/tb_polyvec_pointwise_acc_engine.sv
// Self-checking bench: four engine instances (L,LANES) = (5,16),(1,1),(4,8),(7,256)
// share coefficient memories; expected results are queued at start and popped at done.
// Build with POLYVEC_ACC_INIT_EN defined to also exercise the w_init seed.
module tb_polyvec_pointwise_acc_engine;
    localparam int N     = 256;
    localparam int W     = 32;
    localparam int Q     = 8380417;
    localparam int QINV  = 58728449;
    localparam int NDUT  = 4;
    localparam int LMAX  = 7;

    function automatic int cfg_l(input int g);
        return (g == 0) ? 5 : (g == 1) ? 1 : (g == 2) ? 4 : 7;
    endfunction
    function automatic int cfg_lanes(input int g);
        return (g == 0) ? 16 : (g == 1) ? 1 : (g == 2) ? 8 : 256;
    endfunction

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic [31:0]    u_mem [LMAX][N];
    logic [31:0]    v_mem [LMAX][N];
    logic [31:0]    w_init_mem [N];
    logic           start_v [NDUT];
    logic [N*W-1:0] w_out_v [NDUT];
    logic           busy_v  [NDUT];
    logic           done_v  [NDUT];

    logic [N*W-1:0] exp_q [$];
    int             n_checks = 0;
    int             n_err    = 0;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int LG  = cfg_l(g);
        localparam int LNS = cfg_lanes(g);

        polyvec_pointwise_acc_engine_if #(.L(LG), .N(N), .W(W)) bus ();

        polyvec_pointwise_acc_engine #(
            .L(LG), .N(N), .W(W), .LANES(LNS), .Q(Q), .QINV(QINV)
        ) dut (
            .clock (clock),
            .reset (reset),
            .bus_if(bus)
        );

        always_comb begin
            bus.u_in = '0;
            bus.v_in = '0;
            for (int i = 0; i < LG; i++) begin
                for (int j = 0; j < N; j++) begin
                    bus.u_in[N*W*i + W*j +: W] = u_mem[i][j];
                    bus.v_in[N*W*i + W*j +: W] = v_mem[i][j];
                end
            end
        end
`ifdef POLYVEC_ACC_INIT_EN
        always_comb begin
            bus.w_init = '0;
            for (int j = 0; j < N; j++) bus.w_init[W*j +: W] = w_init_mem[j];
        end
`endif
        assign bus.start  = start_v[g];
        assign w_out_v[g] = bus.w_out;
        assign busy_v[g]  = bus.busy;
        assign done_v[g]  = bus.done;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference Montgomery reduction of the signed product a*b.
    function automatic logic [31:0] mont_ref(input logic [31:0] a, input logic [31:0] b);
        longint      prod;
        longint      tq;
        logic [31:0] lo;
        logic [31:0] t;
        prod = longint'(signed'(a)) * longint'(signed'(b));
        lo   = prod[31:0];
        t    = lo * 32'(QINV);
        tq   = longint'(signed'(t)) * longint'(Q);
        return 32'((prod - tq) >>> 32);
    endfunction

    function automatic logic [N*W-1:0] model_vec(input int lg, input bit use_init);
        logic [N*W-1:0] v;
        logic [31:0]    acc;
        for (int j = 0; j < N; j++) begin
            acc = use_init ? w_init_mem[j] : 32'd0;
            for (int i = 0; i < lg; i++) acc = acc + mont_ref(u_mem[i][j], v_mem[i][j]);
            v[W*j +: W] = acc;
        end
        return v;
    endfunction

    function automatic logic [N*W-1:0] const_vec(input logic [31:0] c);
        logic [N*W-1:0] v;
        for (int j = 0; j < N; j++) v[W*j +: W] = c;
        return v;
    endfunction

    function automatic logic [31:0] rand_coeff();
        return $urandom_range(2*Q - 2, 0) - (Q - 1);
    endfunction

    task automatic fill(input logic [31:0] uc, input logic [31:0] vc, input bit u_rand, input bit v_rand);
        for (int i = 0; i < LMAX; i++) begin
            for (int j = 0; j < N; j++) begin
                u_mem[i][j] = u_rand ? rand_coeff() : uc;
                v_mem[i][j] = v_rand ? rand_coeff() : vc;
            end
        end
    endtask

    // Called just after a negedge with the engine idle: raise start, time the
    // operation, then pop the expected vector and compare every coefficient.
    task automatic run_op(input int g, input bit hold_start, input string tag);
        int             exp_lat;
        int             cyc;
        int             busy_cnt;
        bit             seen;
        logic [N*W-1:0] exp;
        exp_lat = cfg_l(g) * (N / cfg_lanes(g)) + 2;
        start_v[g] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        busy_cnt = busy_v[g] ? 1 : 0;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 3000) begin
            @(posedge clock);
            cyc++;
            @(negedge clock);
            if (busy_v[g]) busy_cnt++;
            if (done_v[g]) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
        check({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            for (int j = 0; j < N; j++)
                check($sformatf("%s_w[%0d]", tag, j), w_out_v[g][W*j +: W], exp[W*j +: W]);
        end
        if (!hold_start) begin
            start_v[g] = 1'b0;
            @(negedge clock);
        end
    endtask

    initial begin
        int busy_hi;
        int done_lo;
        reset = 1'b1;
        for (int g = 0; g < NDUT; g++) start_v[g] = 1'b0;
        for (int j = 0; j < N; j++) w_init_mem[j] = 32'd0;
        fill(32'd0, 32'd0, 1'b0, 1'b0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("rst_busy%0d", g), 32'(busy_v[g]), 32'd0);
            check($sformatf("rst_done%0d", g), 32'(done_v[g]), 32'd0);
            check($sformatf("rst_w_nonzero%0d", g), 32'(|w_out_v[g]), 32'd0);
        end
        reset = 1'b0;
        @(negedge clock);

        // All-ones inputs: every coefficient is 5*mont(1); start stays high afterwards.
        fill(32'd1, 32'd1, 1'b0, 1'b0);
        exp_q.push_back(const_vec(32'hFFF741E0));
        run_op(0, 1'b1, "ones");

        // start held high in DONE: no restart, done stays up, result holds.
        busy_hi = 0;
        done_lo = 0;
        repeat (50) begin
            @(posedge clock);
            @(negedge clock);
            if (busy_v[0]) busy_hi++;
            if (!done_v[0]) done_lo++;
        end
        check("hold_busy_cycles", 32'(busy_hi), 32'd0);
        check("hold_done_low_cycles", 32'(done_lo), 32'd0);
        check("hold_w0", w_out_v[0][31:0], 32'hFFF741E0);
        start_v[0] = 1'b0;
        @(negedge clock);

        // One low cycle later a new accept happens: u=0 clears the previous result.
        fill(32'd0, 32'd0, 1'b0, 1'b1);
        exp_q.push_back(const_vec(32'd0));
        run_op(0, 1'b0, "zero_u");

        // Reset at accept+40 aborts the run and clears all outputs.
        fill(32'd0, 32'd0, 1'b1, 1'b1);
        start_v[0] = 1'b1;
        @(posedge clock);
        repeat (39) @(posedge clock);
        @(negedge clock);
        check("mid_busy", 32'(busy_v[0]), 32'd1);
        reset = 1'b1;
        start_v[0] = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("abort_busy", 32'(busy_v[0]), 32'd0);
        check("abort_done", 32'(done_v[0]), 32'd0);
        check("abort_w_nonzero", 32'(|w_out_v[0]), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        exp_q.push_back(model_vec(cfg_l(0), 1'b0));
        run_op(0, 1'b0, "after_abort");

        // Random vectors on the other (L, LANES) shapes.
        for (int g = 1; g < NDUT; g++) begin
            fill(32'd0, 32'd0, 1'b1, 1'b1);
            exp_q.push_back(model_vec(cfg_l(g), 1'b0));
            run_op(g, 1'b0, $sformatf("rand_g%0d", g));
        end

`ifdef POLYVEC_ACC_INIT_EN
        // Seeded accumulation: w_init=7 on top of the all-ones result.
        fill(32'd1, 32'd1, 1'b0, 1'b0);
        for (int j = 0; j < N; j++) w_init_mem[j] = 32'd7;
        exp_q.push_back(const_vec(32'hFFF741E7));
        run_op(0, 1'b0, "init_seed");
        for (int j = 0; j < N; j++) w_init_mem[j] = rand_coeff();
        fill(32'd0, 32'd0, 1'b1, 1'b1);
        exp_q.push_back(model_vec(cfg_l(2), 1'b1));
        run_op(2, 1'b0, "init_rand");
`endif

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
